// File: rtl/multicycle_control_if.sv
// Control/datapath boundary for the multicycle controller: instruction fields,
// status inputs and all datapath strobes, selects and status outputs.
interface multicycle_control_if;
    logic [5:0] Op;
    logic [5:0] Fun;
    logic       equal;
    logic       mem_ready;
    logic       IRWr;
    logic       PCWr;
    logic       RegWr;
    logic       RegDst;
    logic       ExtOp;
    logic       ALUSrc;
    logic       MemRd;
    logic       MemWr;
    logic       MemtoReg;
    logic [1:0] nPC_sel;
    logic [2:0] ALUctr;
    logic [2:0] state;
    logic       retired;
    logic       halted;

    modport master (
        input  Op, Fun, equal, mem_ready,
        output IRWr, PCWr, RegWr, RegDst, ExtOp, ALUSrc, MemRd, MemWr, MemtoReg,
        output nPC_sel, ALUctr, state, retired, halted
    );

    modport slave (
        output Op, Fun, equal, mem_ready,
        input  IRWr, PCWr, RegWr, RegDst, ExtOp, ALUSrc, MemRd, MemWr, MemtoReg,
        input  nPC_sel, ALUctr, state, retired, halted
    );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle MIPS-subset controller: FETCH/DECODE/EXEC/MEM/WB sequencing.
// Define ILLEGAL_HALT_EN to trap illegal instructions in a sticky HALT state.
module multicycle_control (
    input  logic                 clk,
    input  logic                 nReset,
    multicycle_control_if.master bus
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd7
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] NPC_SEQ = 2'b00;
    localparam logic [1:0] NPC_BR  = 2'b01;
    localparam logic [1:0] NPC_JMP = 2'b10;

    state_e     state_q, state_d;
    logic [5:0] op_q, op_d;
    logic [5:0] fun_q, fun_d;

    logic       irwr, pcwr, regwr, regdst, extop, alusrc, memrd, memwr, memtoreg;
    logic [1:0] npc_sel;
    logic [2:0] aluctr;
    logic       retired, halted;

    function automatic logic is_legal(input logic [5:0] op, input logic [5:0] fun);
        case (op)
            OP_RTYPE: is_legal = fun inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
            OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_ORI, OP_J: is_legal = 1'b1;
            default: is_legal = 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] alu_for_fun(input logic [5:0] fun);
        case (fun)
            FN_SUB:  alu_for_fun = ALU_SUB;
            FN_AND:  alu_for_fun = ALU_AND;
            FN_OR:   alu_for_fun = ALU_OR;
            FN_SLT:  alu_for_fun = ALU_SLT;
            default: alu_for_fun = ALU_ADD;
        endcase
    endfunction

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q <= FETCH;
            op_q    <= '0;
            fun_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            fun_q   <= fun_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        fun_d    = fun_q;
        irwr     = 1'b0;
        pcwr     = 1'b0;
        regwr    = 1'b0;
        regdst   = 1'b0;
        extop    = 1'b0;
        alusrc   = 1'b0;
        memrd    = 1'b0;
        memwr    = 1'b0;
        memtoreg = 1'b0;
        npc_sel  = NPC_SEQ;
        aluctr   = ALU_AND;
        retired  = 1'b0;
        halted   = 1'b0;

        case (state_q)
            FETCH: begin
                memrd = 1'b1;
                if (bus.mem_ready) begin
                    irwr    = 1'b1;
                    pcwr    = 1'b1;
                    npc_sel = NPC_SEQ;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                // Legality is judged on the live IR fields; later states see only the latched copy.
                op_d  = bus.Op;
                fun_d = bus.Fun;
                if (is_legal(bus.Op, bus.Fun)) begin
                    state_d = EXEC;
                end else begin
`ifdef ILLEGAL_HALT_EN
                    state_d = HALT;
`else
                    retired = 1'b1;
                    state_d = FETCH;
`endif
                end
            end
            EXEC: begin
                case (op_q)
                    OP_RTYPE: begin
                        aluctr  = alu_for_fun(fun_q);
                        state_d = WB;
                    end
                    OP_LW, OP_SW: begin
                        alusrc  = 1'b1;
                        extop   = 1'b1;
                        aluctr  = ALU_ADD;
                        state_d = MEM;
                    end
                    OP_ADDI: begin
                        alusrc  = 1'b1;
                        extop   = 1'b1;
                        aluctr  = ALU_ADD;
                        state_d = WB;
                    end
                    OP_ORI: begin
                        alusrc  = 1'b1;
                        aluctr  = ALU_OR;
                        state_d = WB;
                    end
                    OP_BEQ, OP_BNE: begin
                        extop   = 1'b1;
                        aluctr  = ALU_SUB;
                        npc_sel = NPC_BR;
                        pcwr    = (op_q == OP_BEQ) ? bus.equal : !bus.equal;
                        retired = 1'b1;
                        state_d = FETCH;
                    end
                    OP_J: begin
                        pcwr    = 1'b1;
                        npc_sel = NPC_JMP;
                        retired = 1'b1;
                        state_d = FETCH;
                    end
                    default: state_d = FETCH;
                endcase
            end
            MEM: begin
                if (op_q == OP_LW) memrd = 1'b1;
                else               memwr = 1'b1;
                if (bus.mem_ready) begin
                    if (op_q == OP_LW) begin
                        state_d = WB;
                    end else begin
                        retired = 1'b1;
                        state_d = FETCH;
                    end
                end
            end
            WB: begin
                regwr    = 1'b1;
                regdst   = (op_q == OP_RTYPE);
                memtoreg = (op_q == OP_LW);
                retired  = 1'b1;
                state_d  = FETCH;
            end
            HALT: begin
                halted  = 1'b1;
                state_d = HALT;
            end
            default: state_d = FETCH;
        endcase
    end

    // Reset must silence every strobe in the same cycle, even though state already reads FETCH.
    always_comb begin
        bus.IRWr     = nReset & irwr;
        bus.PCWr     = nReset & pcwr;
        bus.RegWr    = nReset & regwr;
        bus.RegDst   = nReset & regdst;
        bus.ExtOp    = nReset & extop;
        bus.ALUSrc   = nReset & alusrc;
        bus.MemRd    = nReset & memrd;
        bus.MemWr    = nReset & memwr;
        bus.MemtoReg = nReset & memtoreg;
        bus.nPC_sel  = nReset ? npc_sel : '0;
        bus.ALUctr   = nReset ? aluctr  : '0;
        bus.retired  = nReset & retired;
        bus.halted   = nReset & halted;
        bus.state    = state_q;
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Trace-based bench: each instruction expands into an expected per-cycle output
// trace built from the instruction-class rules; the DUT is compared every cycle.
module tb_multicycle_control;

    logic clk = 1'b0;
    logic nReset;
    always #5 clk = ~clk;

    multicycle_control_if bus ();

    multicycle_control dut (
        .clk    (clk),
        .nReset (nReset),
        .bus    (bus)
    );

    typedef struct packed {
        logic       irwr, pcwr, regwr, regdst, extop, alusrc, memrd, memwr, memtoreg;
        logic [1:0] npc;
        logic [2:0] aluctr;
        logic [2:0] st;
        logic       ret, hlt;
    } out_t;

    typedef struct {
        logic       mr;
        logic       eq;
        logic [5:0] op;
        logic [5:0] fun;
        out_t       exp;
        string      tag;
    } step_t;

    step_t q[$];
    int total = 0;
    int bad   = 0;

    logic [5:0] legal_ops  [7] = '{6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h0D, 6'h02};
    logic [5:0] legal_funs [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};

    function automatic bit legal(logic [5:0] op, logic [5:0] fun);
        if (op == 6'h00) begin
            foreach (legal_funs[i]) if (legal_funs[i] == fun) return 1'b1;
            return 1'b0;
        end
        foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [2:0] alu_of(logic [5:0] fun);
        case (fun)
            6'h20: return 3'b010;
            6'h22: return 3'b110;
            6'h24: return 3'b000;
            6'h25: return 3'b001;
            default: return 3'b111;
        endcase
    endfunction

    function automatic logic [5:0] r6();
        return 6'($urandom);
    endfunction

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic out_t observe();
        out_t o;
        o.irwr = bus.IRWr;   o.pcwr = bus.PCWr;     o.regwr = bus.RegWr;
        o.regdst = bus.RegDst; o.extop = bus.ExtOp; o.alusrc = bus.ALUSrc;
        o.memrd = bus.MemRd; o.memwr = bus.MemWr;   o.memtoreg = bus.MemtoReg;
        o.npc = bus.nPC_sel; o.aluctr = bus.ALUctr; o.st = bus.state;
        o.ret = bus.retired; o.hlt = bus.halted;
        return o;
    endfunction

    task automatic push(logic mr, logic eq, logic [5:0] op, logic [5:0] fun, out_t o, string tag);
        step_t s;
        s.mr = mr; s.eq = eq; s.op = op; s.fun = fun; s.exp = o; s.tag = tag;
        q.push_back(s);
    endtask

    task automatic check(string tag, int cyc, out_t obs, out_t exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cyc%0d observed=%05h expected=%05h (state %0d vs %0d)",
                   tag, cyc, obs, exp, obs.st, exp.st);
        end
    endtask

    // Expected trace for one instruction: fs fetch stalls, ms memory stalls,
    // halt_n observed cycles in HALT when trapping is enabled.
    task automatic build(string tag, logic [5:0] op, logic [5:0] fun, logic eq,
                         int fs, int ms, int halt_n);
        out_t o;
        bit   is_lw, is_sw;
        is_lw = (op == 6'h23);
        is_sw = (op == 6'h2B);
        for (int i = 0; i < fs; i++) begin
            o = '0; o.memrd = 1'b1;
            push(1'b0, rb(), r6(), r6(), o, tag);
        end
        o = '0; o.memrd = 1'b1; o.irwr = 1'b1; o.pcwr = 1'b1;
        push(1'b1, rb(), r6(), r6(), o, tag);

        o = '0; o.st = 3'd1;
        if (!legal(op, fun)) begin
`ifdef ILLEGAL_HALT_EN
            push(rb(), rb(), op, fun, o, tag);
            for (int i = 0; i < halt_n; i++) begin
                o = '0; o.st = 3'd7; o.hlt = 1'b1;
                push(rb(), rb(), r6(), r6(), o, tag);
            end
`else
            o.ret = 1'b1;
            push(rb(), rb(), op, fun, o, tag);
            if (halt_n < 0) push(1'b0, 1'b0, 6'h0, 6'h0, o, tag);
`endif
            return;
        end
        push(rb(), rb(), op, fun, o, tag);

        o = '0; o.st = 3'd2;
        if (op == 6'h00) begin
            o.aluctr = alu_of(fun);
        end else begin
            case (op)
                6'h23, 6'h2B, 6'h08: begin o.alusrc = 1'b1; o.extop = 1'b1; o.aluctr = 3'b010; end
                6'h0D: begin o.alusrc = 1'b1; o.aluctr = 3'b001; end
                6'h04, 6'h05: begin
                    o.extop = 1'b1; o.aluctr = 3'b110; o.npc = 2'b01; o.ret = 1'b1;
                    o.pcwr = (op == 6'h04) ? eq : !eq;
                end
                default: begin o.pcwr = 1'b1; o.npc = 2'b10; o.ret = 1'b1; end
            endcase
        end
        push(rb(), eq, r6(), r6(), o, tag);
        if (op == 6'h04 || op == 6'h05 || op == 6'h02) return;

        if (is_lw || is_sw) begin
            for (int i = 0; i <= ms; i++) begin
                o = '0; o.st = 3'd3; o.memrd = is_lw; o.memwr = is_sw;
                o.ret = is_sw && (i == ms);
                push(i == ms, rb(), r6(), r6(), o, tag);
            end
            if (is_sw) return;
        end

        o = '0; o.st = 3'd4; o.regwr = 1'b1; o.ret = 1'b1;
        o.regdst = (op == 6'h00); o.memtoreg = is_lw;
        push(rb(), rb(), r6(), r6(), o, tag);
    endtask

    task automatic run(int n);
        step_t s;
        int k = 0;
        while (q.size() > 0 && k < n) begin
            s = q.pop_front();
            @(negedge clk);
            bus.mem_ready = s.mr; bus.equal = s.eq; bus.Op = s.op; bus.Fun = s.fun;
            #1;
            check(s.tag, k, observe(), s.exp);
            k++;
        end
        q.delete();
    endtask

    task automatic do_reset(string tag);
        out_t o;
        nReset = 1'b0;
        bus.mem_ready = 1'b0;
        #1;
        o = '0;
        check({tag, "_asserted"}, 0, observe(), o);
        @(posedge clk);
        @(negedge clk);
        bus.mem_ready = 1'b1;
        #1;
        check({tag, "_held"}, 1, observe(), o);
        bus.mem_ready = 1'b0;
        nReset = 1'b1;
        #1;
        o.memrd = 1'b1;
        check({tag, "_release"}, 2, observe(), o);
    endtask

    initial begin
        logic [5:0] op, fun;
        int         pick;
        nReset = 1'b1;
        bus.Op = '0; bus.Fun = '0; bus.equal = 1'b0; bus.mem_ready = 1'b0;
        #1;
        do_reset("por");

        build("add",     6'h00, 6'h20, 1'b0, 0, 0, 0); run(1000);
        build("lw_wait", 6'h23, r6(),  1'b0, 0, 3, 0); run(1000);
        build("beq_eq1", 6'h04, r6(),  1'b1, 0, 0, 0); run(1000);
        build("beq_eq0", 6'h04, r6(),  1'b0, 0, 0, 0); run(1000);
        build("bne_eq0", 6'h05, r6(),  1'b0, 0, 0, 0); run(1000);
        build("bne_eq1", 6'h05, r6(),  1'b1, 1, 0, 0); run(1000);
        build("j",       6'h02, r6(),  1'b0, 0, 0, 0); run(1000);
        build("sw",      6'h2B, r6(),  1'b0, 2, 1, 0); run(1000);
        build("addi",    6'h08, r6(),  1'b0, 0, 0, 0); run(1000);
        build("ori",     6'h0D, r6(),  1'b0, 0, 0, 0); run(1000);
        build("sub",     6'h00, 6'h22, 1'b0, 0, 0, 0); run(1000);
        build("and",     6'h00, 6'h24, 1'b0, 0, 0, 0); run(1000);
        build("or",      6'h00, 6'h25, 1'b0, 0, 0, 0); run(1000);
        build("slt",     6'h00, 6'h2A, 1'b0, 0, 0, 0); run(1000);
        build("rbadfun", 6'h00, 6'h21, 1'b0, 0, 0, 3); run(1000);
`ifdef ILLEGAL_HALT_EN
        do_reset("rst_after_badfun");
`endif
        build("illegal", 6'h3F, 6'h00, 1'b0, 0, 0, 20); run(1000);
`ifdef ILLEGAL_HALT_EN
        do_reset("rst_after_halt");
`endif
        build("add_after", 6'h00, 6'h20, 1'b0, 0, 0, 0); run(1000);

        build("sw_rst", 6'h2B, r6(), 1'b0, 0, 4, 0); run(4);
        do_reset("rst_mid_mem");
        build("fetch_rst", 6'h00, 6'h20, 1'b0, 3, 0, 0); run(2);
        do_reset("rst_mid_fetch");

        for (int n = 0; n < 60; n++) begin
            pick = $urandom_range(0, 12);
            fun  = r6();
            if (pick < 7) begin
                op = legal_ops[pick];
            end else if (pick < 12) begin
                op  = 6'h00;
                fun = legal_funs[pick - 7];
            end else begin
                op = r6();
                if (legal(op, fun)) op = 6'h3F;
            end
            build($sformatf("rnd%0d_op%02h", n, op), op, fun, rb(),
                  $urandom_range(0, 2), $urandom_range(0, 3), 4);
            run(1000);
`ifdef ILLEGAL_HALT_EN
            if (!legal(op, fun)) do_reset("rnd_rst");
`endif
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameters: none; all encodings are fixed by this document.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 nReset  input  1  asynchronous, active-low reset.
REQ-004 Op  input  6  opcode field of the instruction register.
REQ-005 Fun  input  6  function field of the instruction register.
REQ-006 equal  input  1  ALU zero flag, valid in EXEC.
REQ-007 mem_ready  input  1  memory handshake; access completes on a cycle where it is high.
REQ-008 IRWr, PCWr, RegWr, RegDst, ExtOp, ALUSrc, MemRd, MemWr, MemtoReg  output  1 each  datapath strobes and selects.
REQ-009 nPC_sel  output  2  next-PC select: 00 PC+4, 01 branch target, 10 jump target.
REQ-010 ALUctr  output  3  ALU operation: 010 add, 110 sub, 000 and, 001 or, 111 slt.
REQ-011 state  output  3  current state: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=7.
REQ-012 retired  output  1  one-cycle pulse when an instruction completes.
REQ-013 halted  output  1  high while in HALT.

Function
REQ-014 Outputs SHALL be combinational from state and the latched Op/Fun. Outputs not listed for a state SHALL be 0.
REQ-015 FETCH: MemRd=1. While mem_ready=0, hold. When mem_ready=1: IRWr=1, PCWr=1, nPC_sel=00, next state DECODE.
REQ-016 DECODE: latch Op/Fun internally. The EXEC, MEM and WB states SHALL use only the latched copies.
REQ-017 Legal instructions:
- R-type (Op=000000) with Fun add 100000, sub 100010, and 100100, or 100101, slt 101010.
- lw 100011, sw 101011, beq 000100, bne 000101, addi 001000, ori 001101, j 000010.
REQ-018 EXEC, R-type: ALUSrc=0, ALUctr per Fun, next state WB.
REQ-019 EXEC, lw/sw/addi: ALUSrc=1, ExtOp=1, ALUctr=010. lw/sw go to MEM; addi goes to WB.
REQ-020 EXEC, ori: ALUSrc=1, ExtOp=0, ALUctr=001, next state WB.
REQ-021 EXEC, beq/bne: ALUSrc=0, ExtOp=1, ALUctr=110, nPC_sel=01.
- PCWr=equal for beq; PCWr=!equal for bne.
- retired=1, next state FETCH.
REQ-022 EXEC, j: PCWr=1, nPC_sel=10, retired=1, next state FETCH.
REQ-023 MEM: lw drives MemRd=1; sw drives MemWr=1. Hold while mem_ready=0.
- lw with mem_ready=1: next state WB.
- sw with mem_ready=1: retired=1, next state FETCH.
REQ-024 WB: RegWr=1 for exactly one cycle, retired=1, next state FETCH.
- RegDst=1 for R-type, 0 otherwise.
- MemtoReg=1 for lw only.
REQ-025 With mem_ready tied high, cycle counts SHALL be: R-type/addi/ori 4, lw 5, sw 4, beq/bne/j 3.
REQ-026 MemRd and MemWr SHALL never be asserted together. IRWr SHALL assert only in FETCH.

Reset
REQ-027 nReset low SHALL immediately force state=FETCH, clear the latched Op/Fun to 0, and drive every strobe and retired/halted to 0, including mid-MEM or mid-FETCH.
REQ-028 The first FETCH after reset deassertion SHALL begin on the next rising edge.

Configuration
REQ-029 Macro ILLEGAL_HALT_EN.
- Defined: an illegal Op/Fun in DECODE goes to HALT, which is sticky until reset. In HALT, halted=1 and all strobes are 0.
- Undefined: an illegal instruction goes from DECODE to FETCH with retired=1 (NOP), and HALT is unreachable.

Verification
REQ-030 mem_ready=1; R-type add (Op=0, Fun=100000) -> states 0,1,2,4. ALUctr=010 in EXEC. RegWr=1 and RegDst=1 in WB. retired pulses in cycle 4.
REQ-031 lw with mem_ready low for 3 MEM cycles -> MEM held 4 cycles with MemRd=1. Then WB with MemtoReg=1 and RegWr=1. Total 8 cycles.
REQ-032 beq with equal=1 -> PCWr=1, nPC_sel=01 in EXEC. Repeat with equal=0 -> PCWr=0. bne with equal=0 -> PCWr=1.
REQ-033 Op=111111 -> with ILLEGAL_HALT_EN: state=7, halted=1, held 20 cycles. Without: returns to FETCH with retired=1.
REQ-034 nReset low during sw MEM (MemWr=1) -> MemWr drops the same cycle and state=0. After release, FETCH with MemRd=1.
